bram_pipelined: RTL and testbench
=================================

// Module: bram_pipelined
//
// PURPOSE
// - Simple dual-port block RAM: one write port with byte enables, one read port.
// - Read latency is set by a parameter; a valid strobe is returned with each read.
// - A built-in zero-fill engine runs after reset or on request.
// - Used as on-chip buffer behind MMIO/DMA logic that needs rd_valid tracking.
//
// PARAMETERS
// - DATA_WIDTH  32  word width in bits; must be a multiple of 8
// - ADDR_WIDTH  10  address bits; depth = 2**ADDR_WIDTH words
// - RD_LATENCY   2  cycles from accepted rd_en to rd_valid; legal range 1..8
// - INIT_CLEAR   1  1 = zero-fill the whole memory after every reset; 0 = no fill
//
// PORTS
// - clk      in   1             clock; all logic on the rising edge
// - rst_n    in   1             asynchronous reset, active-low
// - clear    in   1             1-cycle pulse that starts a zero-fill; sampled only when busy=0
// - busy     out  1             1 while the zero-fill runs; ports are ignored while busy=1
// - wr_en    in   1             write request
// - wr_addr  in   ADDR_WIDTH    write address
// - wr_be    in   DATA_WIDTH/8  byte enables; bit i controls wr_data[8i+7:8i]
// - wr_data  in   DATA_WIDTH    write data
// - rd_en    in   1             read request
// - rd_addr  in   ADDR_WIDTH    read address
// - rd_valid out  1             rd_data holds the result of the read accepted RD_LATENCY cycles earlier
// - rd_data  out  DATA_WIDTH    read data; holds its last value when rd_valid=0
//
// BEHAVIOUR
// - Reset values: rd_valid=0, rd_data=0, valid pipeline cleared.
//   - busy resets to INIT_CLEAR; FSM resets to CLEAR if INIT_CLEAR=1, else IDLE.
// - Memory array contents are not reset.
// - FSM states: IDLE and CLEAR.
//   - IDLE -> CLEAR when clear=1: fill counter set to 0, busy=1 from the next cycle.
//   - In CLEAR, one word per cycle: mem[cnt] <= 0, cnt++.
//   - CLEAR -> IDLE after address 2**ADDR_WIDTH-1 is written; busy=0 on the following cycle.
//   - A fill takes exactly 2**ADDR_WIDTH cycles.
// - While busy=1: wr_en, rd_en and clear are ignored (no write, no valid issued).
// - Reads accepted before a fill starts still complete; their data may be pre-fill.
// - rst_n low mid-fill: aborts at once. If INIT_CLEAR=1 the fill restarts from address 0.
// - Writes: when wr_en=1 and busy=0, only enabled bytes of mem[wr_addr] update.
//   - wr_be=0 is a no-op.
// - Reads: when rd_en=1 and busy=0, rd_valid=1 exactly RD_LATENCY cycles later.
//   - Back-to-back reads give back-to-back valids; no stall, no backpressure.
// - Pipeline structure: first stage is the RAM output register.
//   - The remaining RD_LATENCY-1 stages are plain data/valid registers.
// - Read and write to the same address in the same cycle: read returns OLD data.
// - Read and write to different addresses never interfere.
// - Addresses are unsigned; there is no wrap and no out-of-range case (full decode).
//
// CONFIGURATION
// - BRAM_WRITE_FIRST_EN defined: same-address read/write returns NEW data.
//   - Enabled bytes come from wr_data; other bytes come from memory.
//   - Implemented as a bypass mux on the first read stage.
// - BRAM_WRITE_FIRST_EN undefined: old-data behaviour as above; no bypass logic.
//
// TESTING
// - Reset, INIT_CLEAR=1, ADDR_WIDTH=4:
//   busy=1 for 16 cycles then 0; reading all 16 addresses returns 0.
// - Write 0xDEADBEEF to addr 3 with wr_be=4'hF, then wr_be=4'b0010 with data 0x0000_5500:
//   rd addr 3 -> 0xDEAD55EF with rd_valid exactly RD_LATENCY cycles after rd_en.
// - RD_LATENCY=3, rd_en high 4 consecutive cycles on addrs 0..3:
//   rd_valid high on 4 consecutive cycles starting 3 cycles later, data in order.
// - addr 5 = 0x11; same cycle write 0x22 to addr 5 and read addr 5:
//   returns 0x11, or 0x22 with BRAM_WRITE_FIRST_EN; next read returns 0x22.
// - Pulse clear while idle, assert wr_en/rd_en during busy:
//   no memory change, no rd_valid; all words read 0 afterwards.
// - Drop rst_n for 1 cycle mid-fill:
//   rd_valid=0 and rd_data=0 immediately; busy=1 again, fill restarts and lasts a full 2**ADDR_WIDTH cycles.

Source files
------------

// File: rtl/bram_pipelined.sv
// Simple dual-port RAM: byte-enable write port, read port with RD_LATENCY-deep data/valid pipeline, zero-fill engine.
// Latency: rd_en -> rd_valid in RD_LATENCY cycles; a fill occupies 2**ADDR_WIDTH cycles. Optional macro: BRAM_WRITE_FIRST_EN.
// Backpressure: none; reads never stall, and wr_en/rd_en/clear are dropped while busy.
module bram_pipelined #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;
    localparam state_t RST_STATE = (INIT_CLEAR != 1'b0) ? CLEAR : IDLE;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] pipe_dat [RD_LATENCY];
    logic [RD_LATENCY-1:0] pipe_vld;

    assign busy   = (state == CLEAR);
    assign wr_acc = wr_en && !busy;
    assign rd_acc = rd_en && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Array has no reset; the fill engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
`ifdef BRAM_WRITE_FIRST_EN
        if (wr_acc && (wr_addr == rd_addr)) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    rd_word[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
`endif
    end

    // Stage 0 is the RAM output register; every stage only loads on a valid so rd_data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= rd_word;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    assign rd_valid = pipe_vld[RD_LATENCY-1];
    assign rd_data  = pipe_dat[RD_LATENCY-1];

endmodule

// File: tb/tb_bram_pipelined.sv
// Randomized and directed bench for bram_pipelined against a word-array/queue reference model.
module tb_bram_pipelined;
    localparam int AW    = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          busy;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_be = '0;
    logic [31:0]   wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [31:0]   rd_data;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          fill_left = 0;
    logic [31:0] last_dat = '0;
    logic [31:0] mmem [DEPTH];

    typedef struct {
        int          due;
        logic [31:0] dat;
    } rd_t;
    rd_t pend[$];

    always #5 clk = ~clk;

    bram_pipelined #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(LAT),
        .INIT_CLEAR(1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_valid(rd_valid),
        .rd_data (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic we, input int wa, input logic [3:0] be, input logic [31:0] wd,
                         input logic re, input int ra, input logic clr);
        wr_en   = we;
        wr_addr = wa[AW-1:0];
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra[AW-1:0];
        clear   = clr;
    endtask

    task automatic idle();
        drive(1'b0, 0, 4'h0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    // Model consumes this cycle's inputs, then the clock advances and outputs are compared.
    task automatic tick();
        logic [31:0] d;
        rd_t         r;
        if (fill_left > 0) begin
            fill_left--;
        end else begin
            if (rd_en) begin
                d = mmem[rd_addr];
`ifdef BRAM_WRITE_FIRST_EN
                if (wr_en && (wr_addr == rd_addr)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_be[b]) d[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
`endif
                r.due = cyc + LAT;
                r.dat = d;
                pend.push_back(r);
            end
            if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) mmem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
            if (clear) begin
                for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
                fill_left = DEPTH;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("busy", 32'(busy), 32'(fill_left > 0));
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", rd_data, r.dat);
            last_dat = r.dat;
        end else begin
            chk("rd_valid_idle", 32'(rd_valid), 32'd0);
            chk("rd_data_hold", rd_data, last_dat);
        end
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        pend.delete();
        last_dat  = '0;
        fill_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        #1;
        chk("rst_busy_release", 32'(busy), 32'd1);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 0, 4'h0, 32'h0, 1'b1, a, 1'b0);
            tick();
        end
        idle();
        repeat (LAT) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        idle();
        #2;
        // Power-up fill, then every word reads zero.
        do_reset();
        repeat (DEPTH) tick();
        read_all();

        // Byte-enable merge.
        drive(1'b1, 3, 4'hF, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        tick();
        drive(1'b1, 3, 4'b0010, 32'h0000_5500, 1'b0, 0, 1'b0);
        tick();
        drive(1'b1, 9, 4'h0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        tick();
        drive(1'b0, 0, 4'h0, 32'h0, 1'b1, 3, 1'b0);
        tick();
        idle();
        repeat (LAT) tick();
        chk("be_merge", rd_data, 32'hDEAD55EF);

        // Back-to-back reads on addresses 0..3.
        for (int a = 0; a < 4; a++) begin
            drive(1'b1, a, 4'hF, 32'h1000_0000 + 32'(a * 17), 1'b0, 0, 1'b0);
            tick();
        end
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 0, 4'h0, 32'h0, 1'b1, a, 1'b0);
            tick();
        end
        idle();
        repeat (LAT) tick();

        // Same-address read/write collision, then a plain re-read.
        drive(1'b1, 5, 4'hF, 32'h11, 1'b0, 0, 1'b0);
        tick();
        drive(1'b1, 5, 4'hF, 32'h22, 1'b1, 5, 1'b0);
        tick();
        drive(1'b0, 0, 4'h0, 32'h0, 1'b1, 5, 1'b0);
        tick();
        idle();
        repeat (LAT) tick();
        chk("collision_reread", rd_data, 32'h22);

        // Random traffic with occasional fills.
        for (int n = 0; n < 800; n++) begin
            drive(1'($urandom), int'($urandom_range(0, DEPTH - 1)), 4'($urandom), $urandom,
                  1'($urandom), int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 63) == 0));
            tick();
        end
        idle();
        repeat (DEPTH + LAT) tick();

        // Clear while idle, with traffic presented during busy.
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, a, 4'hF, 32'hC0DE_0000 + 32'(a), 1'b0, 0, 1'b0);
            tick();
        end
        drive(1'b0, 0, 4'h0, 32'h0, 1'b0, 0, 1'b1);
        tick();
        for (int n = 0; n < DEPTH; n++) begin
            drive(1'b1, int'($urandom_range(0, DEPTH - 1)), 4'hF, $urandom | 32'h1,
                  1'b1, int'($urandom_range(0, DEPTH - 1)), 1'b1);
            tick();
        end
        idle();
        read_all();

        // Reset in the middle of a fill restarts it from the beginning.
        drive(1'b1, 7, 4'hF, 32'hA5A5_5A5A, 1'b0, 0, 1'b0);
        tick();
        drive(1'b0, 0, 4'h0, 32'h0, 1'b1, 7, 1'b0);
        tick();
        idle();
        repeat (LAT) tick();
        drive(1'b0, 0, 4'h0, 32'h0, 1'b0, 0, 1'b1);
        tick();
        idle();
        repeat (5) tick();
        do_reset();
        repeat (DEPTH) tick();
        read_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
